// File: rtl/wei_req_arbiter.sv
// Round-robin weight-delivery arbiter between the PEC array and the weight distributor FIFO.
// One PEC is granted at a time; the grant is held until that PEC acknowledges with pec_get.
module wei_req_arbiter #(
  parameter int NUM_PEC = 48,
  parameter int ID_W    = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               soft_reset,
  input  logic [NUM_PEC-1:0] pec_req,
  input  logic [NUM_PEC-1:0] pec_get,
  input  logic               fifo_rdy,
  output logic               fetch_pls,
  output logic [NUM_PEC-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [CNT_W-1:0]   grant_cnt
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_FIFO = 2'd1;
  localparam logic [1:0] GRANT     = 2'd2;

  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_PEC - 1);

  logic [1:0]      state;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            found;
  int              idx;

  // Search upward from the PEC after the last one served, wrapping at NUM_PEC.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NUM_PEC; i++) begin
      idx  = (int'(last_id) + 1 + i) % NUM_PEC;
      cand = ID_W'(idx);
      if (!found && pec_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign fetch_pls = (state == WAIT_FIFO) && fifo_rdy && found && !soft_reset;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_id  <= '0;
      grant_cnt <= '0;
      last_id   <= LAST_INIT;
    end else if (soft_reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_cnt <= '0;
      last_id   <= LAST_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= WAIT_FIFO;
        end
        WAIT_FIFO: begin
          if (fetch_pls) begin
            state    <= GRANT;
            grant_id <= winner;
            grant    <= NUM_PEC'(1) << winner;
          end
        end
        GRANT: begin
          // Only the granted PEC's acknowledge releases the grant.
          if (pec_get[grant_id]) begin
            state     <= WAIT_FIFO;
            grant     <= '0;
            last_id   <= grant_id;
            grant_cnt <= grant_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
